// File: rtl/data_mem_responder.sv
// Shared data-memory responder: round-robin arbitration of per-lane read/write
// requests onto one external memory port, with four-phase completion back to the lane.
module data_mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic             serving_read;

  logic             found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cidx;
  logic             lane_valid;

  // Rotating priority scan: offsets 0..N-1 from ptr, first requester wins.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    cand    = '0;
    cidx    = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CONSUMERS))
        cand = cand - (IDX_W+1)'(NUM_CONSUMERS);
      cidx = cand[IDX_W-1:0];
      if (!found && (consumer_read_valid[cidx] || consumer_write_valid[cidx])) begin
        found   = 1'b1;
        arb_idx = cidx;
      end
    end
  end

  assign lane_valid = serving_read ? consumer_read_valid[grant] : consumer_write_valid[grant];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      ptr                  <= '0;
      grant                <= '0;
      serving_read         <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= arb_idx;
            // A lane with both valids high gets its read first.
            if (consumer_read_valid[arb_idx]) begin
              serving_read     <= 1'b1;
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[arb_idx*ADDR_BITS +: ADDR_BITS];
              state            <= READ_WAIT;
            end else begin
              serving_read      <= 1'b0;
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[arb_idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[arb_idx*DATA_BITS +: DATA_BITS];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            consumer_read_data[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant] <= 1'b1;
            mem_read_valid             <= 1'b0;
            state                      <= RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            consumer_write_ready[grant] <= 1'b1;
            mem_write_valid             <= 1'b0;
            state                       <= RELAY;
          end
        end
        RELAY: begin
          // A lane that already dropped valid sees ready for a single cycle.
          if (!lane_valid) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            ptr                  <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the data-memory channels that compute cores expose, serving NUM_CONSUMERS request lanes (e.g. two cores × THREADS_PER_BLOCK threads) over one shared external memory port. It arbitrates read and write requests round-robin and forwards one transaction at a time to memory. It returns read data or write acknowledgement to the requesting lane with the four-phase valid/ready handshake the cores use. It sits between the core cluster and the global data memory.

## Interface
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 8, number of request lanes, ≥2
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- consumer_read_valid  input  NUM_CONSUMERS  per-lane read request
- consumer_read_address  input  NUM_CONSUMERS×ADDR_BITS  per-lane read address
- consumer_read_ready  output  NUM_CONSUMERS  per-lane read completion
- consumer_read_data  output  NUM_CONSUMERS×DATA_BITS  per-lane read data
- consumer_write_valid  input  NUM_CONSUMERS  per-lane write request
- consumer_write_address  input  NUM_CONSUMERS×ADDR_BITS  per-lane write address
- consumer_write_data  input  NUM_CONSUMERS×DATA_BITS  per-lane write data
- consumer_write_ready  output  NUM_CONSUMERS  per-lane write completion
- mem_read_valid  output  1  memory read request
- mem_read_address  output  ADDR_BITS
- mem_read_ready  input  1  one-cycle pulse, data valid this cycle
- mem_read_data  input  DATA_BITS
- mem_write_valid  output  1  memory write request
- mem_write_address  output  ADDR_BITS
- mem_write_data  output  DATA_BITS
- mem_write_ready  input  1  one-cycle pulse, write accepted

## Operation
- All outputs are registered. Reset value of every output is 0. The round-robin pointer resets to 0. The FSM resets to IDLE.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- **IDLE**
  - A lane is eligible if its read_valid or write_valid is high.
  - Scan starts at pointer p and runs p, p+1, …, wrapping modulo NUM_CONSUMERS. The first eligible lane g wins.
  - If g has read_valid: latch g and the address, set mem_read_valid=1, go to READ_WAIT.
  - Else: latch g, address and data, set mem_write_valid=1, go to WRITE_WAIT.
  - If lane g has both valids high, the read is served first. The write is taken on a later grant.
  - If no lane is eligible, stay in IDLE.
- **READ_WAIT**
  - mem_read_valid and address are held until mem_read_ready=1.
  - On that cycle: capture mem_read_data into consumer_read_data[g], set consumer_read_ready[g]=1, clear mem_read_valid, go to RELAY.
- **WRITE_WAIT**
  - Same as READ_WAIT on mem_write_ready. Sets consumer_write_ready[g]=1 and clears mem_write_valid.
- **RELAY**
  - The ready of lane g is held until that lane's matching valid is sampled low.
  - Then ready clears, p becomes (g+1) mod NUM_CONSUMERS, and the FSM returns to IDLE.
  - consumer_read_data[g] keeps its value until overwritten by the next read to lane g.
- Mismatched mem ready pulses are ignored: mem_read_ready outside READ_WAIT, and mem_write_ready outside WRITE_WAIT.
- A consumer dropping valid before ready is a protocol violation. The latched transaction still completes. In RELAY, ready is then high for exactly one cycle.
- Only one consumer ready bit is ever high, and never mem_read_valid and mem_write_valid together.
- Reset asserted mid-transaction clears all state and outputs immediately (asynchronously). The memory transaction is abandoned.

## Timing
- Requests are sampled at rising edge k in IDLE. mem_*_valid is high from cycle k+1.
- Memory ready pulse sampled at edge m. Consumer ready and data are visible from cycle m+1.
- Consumer valid sampled low at edge r. Ready is low from r+1, and the FSM is in IDLE for cycle r+1.
- Arbitration for the next request happens at edge r+1, so new mem valid appears at r+2.
- Minimum turnaround is 4 cycles per transaction when memory responds in the first wait cycle.
- Starvation bound: a held request is granted within NUM_CONSUMERS grants.

## Test plan
- **Single read.** Lane 3 reads address 0x2A. Memory returns 0x5C 2 cycles after valid. Required: mem_read_address=0x2A; consumer_read_data[3]=0x5C with ready[3]=1; ready clears one cycle after valid[3] drops.
- **Single write.** Lane 0 writes 0x77 to 0x10. Memory acks after 1 cycle. Required: mem_write_address=0x10, mem_write_data=0x77; write_ready[0] pulses per handshake; no read activity.
- **Round-robin.** All 8 lanes request reads together, each re-requesting immediately after completing, with pointer at 0. Required: grant order 0,1,…,7,0.
- **Contention after pointer move.** After lane 5 is served, lanes 2 and 6 request simultaneously. Required: 6 is granted before 2.
- **Read and write on one lane.** Lane 1 has read and write valid together. Required: read served first, write on a later grant; the mem valids are never both high.
- **Reset and stray pulses.** Reset asserted during READ_WAIT. Required: all outputs 0 asynchronously; FSM in IDLE after release; pointer 0. A stray mem_read_ready in IDLE produces no consumer ready.
